// File: rtl/exe_mem_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use stalls, MEM-stage branch flushes,
// multi-cycle data-memory freezes with a timeout watchdog. Optional counters: HAZARD_PERF_CNT_EN.
module exe_mem_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_exe_memread,
    input  logic [4:0]  id_exe_dstreg,
    input  logic        exe_mem_zero,
    input  logic        exe_mem_beq,
    input  logic        exe_mem_bne,
    input  logic        exe_mem_memread,
    input  logic        exe_mem_memwrite,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_write,
    output logic        pc_src,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_exe_bubble,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        pipe_hold,
    output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] lu_count
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;
    localparam logic [7:0] WAIT_LAST   = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_acc, taken, lu;
    logic       freeze, decode;

    assign mem_acc = exe_mem_memread | exe_mem_memwrite;
    assign taken   = (exe_mem_beq & exe_mem_zero) | (exe_mem_bne & ~exe_mem_zero);
    assign lu      = id_exe_memread & (id_exe_dstreg != 5'd0) &
                     ((id_exe_dstreg == id_rs) | (id_uses_rt & (id_exe_dstreg == id_rt)));

    // Which regime applies this cycle, and the next-state decision.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        freeze        = 1'b0;
        decode        = 1'b0;
        dmem_req      = 1'b0;
        case (state_reg)
            ST_RUN: begin
                dmem_req = mem_acc;
                if (mem_acc && !dmem_ready) begin
                    freeze        = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 8'd0;
                end else begin
                    decode = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    decode     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    freeze        = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                    if (wait_cnt_reg == WAIT_LAST)
                        state_next = ST_ERR;
                end
            end
            default: begin
                freeze = 1'b1;
            end
        endcase
        // Reset aborts any wait immediately, including the request.
        if (!rst_n)
            dmem_req = 1'b0;
    end

    // Pipeline control decoding; reset forces the idle defaults.
    always_comb begin
        pc_write      = 1'b1;
        pc_src        = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        pipe_hold     = 1'b0;
        mem_err       = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                mem_err     = (state_reg == ST_ERR);
            end else if (decode && taken) begin
                pc_src        = 1'b1;
                if_id_flush   = 1'b1;
                id_exe_flush  = 1'b1;
                exe_mem_flush = 1'b1;
            end else if (decode && lu) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_exe_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0]  perf_evt;
    logic [31:0] perf_cnt_reg [3];

    assign perf_evt = {id_exe_bubble, if_id_flush, ~pc_write};

    // Saturating event counters, frozen once the watchdog has tripped.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (!rst_n)
                    perf_cnt_reg[gi] <= 32'd0;
                else if (state_reg != ST_ERR && perf_evt[gi] && perf_cnt_reg[gi] != 32'hFFFF_FFFF)
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
            end
        end
    endgenerate

    assign stall_cycles = perf_cnt_reg[0];
    assign flush_count  = perf_cnt_reg[1];
    assign lu_count     = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_exe_mem_hazard_ctrl.sv
// Directed testbench for exe_mem_hazard_ctrl (MEM_TIMEOUT=4); counter checks when HAZARD_PERF_CNT_EN is defined.
module tb_exe_mem_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_exe_dstreg;
    logic       id_uses_rt, id_exe_memread;
    logic       exe_mem_zero, exe_mem_beq, exe_mem_bne;
    logic       exe_mem_memread, exe_mem_memwrite, dmem_ready;
    logic       dmem_req, pc_write, pc_src, if_id_write, if_id_flush;
    logic       id_exe_bubble, id_exe_flush, exe_mem_flush, pipe_hold, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, lu_count;
`endif

    int checks = 0;
    int errors = 0;

    // {dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_exe_bubble, id_exe_flush, exe_mem_flush, pipe_hold, mem_err}
    logic [9:0] outs;
    assign outs = {dmem_req, pc_write, pc_src, if_id_write, if_id_flush,
                   id_exe_bubble, id_exe_flush, exe_mem_flush, pipe_hold, mem_err};

    localparam logic [9:0] DEF   = 10'b0_1_0_1_0_0_0_0_0_0;
    localparam logic [9:0] FRZ   = 10'b1_0_0_0_0_0_0_0_1_0;
    localparam logic [9:0] LUS   = 10'b0_0_0_0_0_1_0_0_0_0;
    localparam logic [9:0] BR    = 10'b0_1_1_1_1_0_1_1_0_0;
    localparam logic [9:0] ADV   = 10'b1_1_0_1_0_0_0_0_0_0;
    localparam logic [9:0] ADVBR = 10'b1_1_1_1_1_0_1_1_0_0;
    localparam logic [9:0] ERRV  = 10'b0_0_0_0_0_0_0_0_1_1;

    exe_mem_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_exe_memread(id_exe_memread), .id_exe_dstreg(id_exe_dstreg),
        .exe_mem_zero(exe_mem_zero), .exe_mem_beq(exe_mem_beq), .exe_mem_bne(exe_mem_bne),
        .exe_mem_memread(exe_mem_memread), .exe_mem_memwrite(exe_mem_memwrite),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_write(pc_write), .pc_src(pc_src),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_exe_bubble(id_exe_bubble), .id_exe_flush(id_exe_flush),
        .exe_mem_flush(exe_mem_flush), .pipe_hold(pipe_hold), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_exe_memread = 1'b0; id_exe_dstreg = 5'd0;
        exe_mem_zero = 1'b0; exe_mem_beq = 1'b0; exe_mem_bne = 1'b0;
        exe_mem_memread = 1'b0; exe_mem_memwrite = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        exe_mem_memread = 1'b1; dmem_ready = 1'b0; exe_mem_bne = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== DEF) begin
            errors++;
            $display("FAIL reset_forced outs=%b expected=%b", outs, DEF);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== DEF) begin
            errors++;
            $display("FAIL reset_idle outs=%b expected=%b", outs, DEF);
        end
        $display("reset: outs=%b", outs);
        tick();
    endtask

    task automatic test_load_use();
        logic [9:0] exp;
        // {memread, dstreg, rs, rt, uses_rt}
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            case (i)
                0: begin id_exe_memread = 1'b1; id_exe_dstreg = 5'd8; id_rs = 5'd8; exp = LUS; end
                1: begin id_exe_memread = 1'b0; id_exe_dstreg = 5'd8; id_rs = 5'd8; exp = DEF; end
                2: begin id_exe_memread = 1'b1; id_exe_dstreg = 5'd0; id_rs = 5'd0; exp = DEF; end
                3: begin id_exe_memread = 1'b1; id_exe_dstreg = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; exp = LUS; end
                default: begin id_exe_memread = 1'b1; id_exe_dstreg = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0; exp = DEF; end
            endcase
            @(negedge clk);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL load_use[%0d] outs=%b expected=%b", i, outs, exp);
            end
            $display("load_use[%0d]: outs=%b", i, outs);
            tick();
        end
    endtask

    task automatic test_branch();
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            case (i)
                0: begin exe_mem_bne = 1'b1; exe_mem_zero = 1'b0; exp = BR; end
                1: begin exe_mem_bne = 1'b1; exe_mem_zero = 1'b1; exp = DEF; end
                2: begin exe_mem_beq = 1'b1; exe_mem_zero = 1'b1; exp = BR; end
                default: begin exe_mem_beq = 1'b1; exe_mem_zero = 1'b1;
                               id_exe_memread = 1'b1; id_exe_dstreg = 5'd3; id_rs = 5'd3; exp = BR; end
            endcase
            @(negedge clk);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL branch[%0d] outs=%b expected=%b", i, outs, exp);
            end
            $display("branch[%0d]: outs=%b", i, outs);
            tick();
        end
    endtask

    task automatic test_single_cycle_mem();
        idle_inputs();
        exe_mem_memread = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== ADV) begin
            errors++;
            $display("FAIL single_cycle_mem outs=%b expected=%b", outs, ADV);
        end
        $display("single_cycle_mem: outs=%b", outs);
        tick();
    endtask

    // Three not-ready cycles, then the completing cycle, then the pipeline moves on.
    task automatic test_mem_wait();
        logic [9:0] exp;
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            exe_mem_memread = (i < 4);
            dmem_ready      = (i >= 3);
            exp = (i < 3) ? FRZ : ((i == 3) ? ADV : DEF);
            @(negedge clk);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL mem_wait[%0d] outs=%b expected=%b", i, outs, exp);
            end
            $display("mem_wait[%0d]: outs=%b", i, outs);
            tick();
        end
    endtask

    task automatic test_priority();
        logic [9:0] exp;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            exe_mem_memwrite = (i < 3);
            exe_mem_bne      = (i < 3);
            exe_mem_zero     = 1'b0;
            dmem_ready       = (i >= 2);
            exp = (i < 2) ? FRZ : ((i == 2) ? ADVBR : DEF);
            @(negedge clk);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL priority[%0d] outs=%b expected=%b", i, outs, exp);
            end
            $display("priority[%0d]: outs=%b", i, outs);
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        exe_mem_memread = 1'b1; dmem_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (outs !== FRZ) begin
            errors++;
            $display("FAIL mid_wait_frozen outs=%b expected=%b", outs, FRZ);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== DEF) begin
            errors++;
            $display("FAIL mid_wait_reset outs=%b expected=%b", outs, DEF);
        end
        tick();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (outs !== DEF) begin
            errors++;
            $display("FAIL mid_wait_after outs=%b expected=%b", outs, DEF);
        end
        $display("reset_mid_wait: outs=%b", outs);
        tick();
    endtask

    // One RUN freeze cycle, four MEM_WAIT cycles, then ERR until reset.
    task automatic test_timeout();
        logic [9:0] exp;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (i < 5) begin
                exe_mem_memread = 1'b1; dmem_ready = 1'b0;
            end else begin
                exe_mem_memread = 1'b1; dmem_ready = 1'b1;
                exe_mem_bne = 1'b1;
            end
            exp = (i < 5) ? FRZ : ERRV;
            @(negedge clk);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL timeout[%0d] outs=%b expected=%b", i, outs, exp);
            end
            $display("timeout[%0d]: outs=%b", i, outs);
            tick();
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (outs !== DEF) begin
            errors++;
            $display("FAIL timeout_cleared outs=%b expected=%b", outs, DEF);
        end
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        test_mem_wait();
        idle_inputs();
        id_exe_memread = 1'b1; id_exe_dstreg = 5'd8; id_rs = 5'd8;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd4) begin
            errors++;
            $display("FAIL perf_stall got=%0d expected=4", stall_cycles);
        end
        checks++;
        if (lu_count !== 32'd1) begin
            errors++;
            $display("FAIL perf_lu got=%0d expected=1", lu_count);
        end
        checks++;
        if (flush_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_flush got=%0d expected=0", flush_count);
        end
        exe_mem_bne = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (flush_count !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush_after_branch got=%0d expected=1", flush_count);
        end
        $display("perf: stall=%0d lu=%0d flush=%0d", stall_cycles, lu_count, flush_count);
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_single_cycle_mem();
        test_mem_wait();
        test_priority();
        test_reset_mid_wait();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
